// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between the multicycle MIPS controller and its datapath
//
// Purpose: groups the opcode/memory-handshake inputs and every datapath
// control output of multicycle_control into one bundle.
// Modports:
//   master - the controller: takes opcode and mem_ready, drives all controls
//   slave  - the datapath side: drives opcode and mem_ready, takes all controls
// Signals:
//   opcode[5:0]       instruction[31:26] from the instruction register
//   mem_ready         memory completes the current read/write this cycle
//   pc_write          unconditional PC load
//   pc_write_cond     PC load if ALU zero
//   i_or_d            0 = PC addresses memory, 1 = ALUOut
//   mem_read          memory read request
//   mem_write         memory write request
//   ir_write          load instruction register
//   mem_to_reg        0 = ALUOut, 1 = MDR to register file
//   reg_dst           0 = rt, 1 = rd
//   reg_write         register file write enable
//   alu_src_a         0 = PC, 1 = rs
//   alu_src_b[1:0]    00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   alu_op[1:0]       00 add, 01 sub, 10 funct-decoded
//   inm               alu_op_final overrides alu_op/funct
//   alu_op_final[3:0] direct ALU control for immediate ops
//   pc_source[1:0]    00 ALU, 01 ALUOut, 10 jump target
//   mem_timeout       sticky memory-wait timeout flag
//   trap              illegal-opcode trap flag

interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       inm;
    logic [3:0] alu_op_final;
    logic [1:0] pc_source;
    logic       mem_timeout;
    logic       trap;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               inm, alu_op_final, pc_source, mem_timeout, trap
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               inm, alu_op_final, pc_source, mem_timeout, trap
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle MIPS datapath
//
// Purpose: sequences fetch/decode/execute/memory/writeback over a shared ALU,
// register file and unified memory, driving all datapath controls from the
// 6-bit opcode and stalling on the mem_ready handshake.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    multicycle_control_if.master (opcode, mem_ready in; all controls out)
// Parameters:
//   MEM_WAIT_MAX  memory wait cycles before mem_timeout is flagged (4-bit counter)
// Configuration:
//   MULTICYCLE_ILLEGAL_TRAP_EN  when defined, an illegal opcode parks the FSM in
//   ILLEGAL with trap=1 until reset; otherwise ILLEGAL is a one-cycle NOP.

module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_RTYPE    = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IEXEC    = 4'd10,
        S_IWB      = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    state_t     state;
    state_t     state_next;
    logic [5:0] op_q;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       timeout_q;
    logic       mem_state;
    logic       waiting;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       inm;
    logic [3:0] alu_op_final;
    logic [1:0] pc_source;
    logic       trap;

    function automatic logic [3:0] imm_alu_ctl(input logic [5:0] op);
        case (op)
            OP_ADDI: imm_alu_ctl = 4'b0010;
            OP_ANDI: imm_alu_ctl = 4'b0000;
            OP_ORI:  imm_alu_ctl = 4'b0001;
            OP_SLTI: imm_alu_ctl = 4'b0111;
            default: imm_alu_ctl = 4'b0000;
        endcase
    endfunction

    function automatic logic is_mem_state(input state_t s);
        is_mem_state = (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                          state_next = S_RTYPE;
                    OP_LW, OP_SW:                      state_next = S_MEMADDR;
                    OP_BEQ:                            state_next = S_BRANCH;
                    OP_J:                              state_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IEXEC;
                    default:                           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADDR:  state_next = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_next = S_FETCH;
            S_RTYPE:    state_next = S_RWB;
            S_RWB:      state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_IEXEC:    state_next = S_IWB;
            S_IWB:      state_next = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_ILLEGAL:  state_next = S_ILLEGAL;
`else
            S_ILLEGAL:  state_next = S_FETCH;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode; only FETCH looks at mem_ready so the IR/PC strobes fire
    // exactly on the completion cycle and never while stalled.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        inm           = 1'b0;
        alu_op_final  = 4'b0000;
        pc_source     = 2'b00;
        trap          = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_RTYPE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_IEXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                inm          = 1'b1;
                alu_op_final = imm_alu_ctl(op_q);
            end
            S_IWB: begin
                reg_write    = 1'b1;
                inm          = 1'b1;
                alu_op_final = imm_alu_ctl(op_q);
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_ILLEGAL: trap = 1'b1;
`endif
            default: ;
        endcase
    end

    // The opcode register is loaded as DECODE exits so IEXEC/IWB keep a stable
    // ALU control even if the IR input changes afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= 6'd0;
        end else if (state == S_DECODE) begin
            op_q <= bus.opcode;
        end
    end

    assign mem_state = is_mem_state(state);
    assign waiting   = mem_state && !bus.mem_ready;

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (state_next != state && is_mem_state(state_next)) begin
            wait_cnt_next = 4'd0;
        end else if (waiting && wait_cnt != WAIT_MAX) begin
            wait_cnt_next = wait_cnt + 4'd1;
        end
    end

    // Timeout is flagged on the edge that ends the MEM_WAIT_MAX-th waiting
    // cycle; the FSM keeps waiting regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_next;
            if (waiting && wait_cnt_next == WAIT_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.inm           = inm;
    assign bus.alu_op_final  = alu_op_final;
    assign bus.pc_source     = pc_source;
    assign bus.mem_timeout   = timeout_q;
    assign bus.trap          = trap;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control

module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       inm;
        logic [3:0] alu_op_final;
        logic [1:0] pc_source;
        logic       mem_timeout;
        logic       trap;
    } t_ctl;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       rdy;
        logic       rst;
        t_ctl       exp;
    } vec_t;

    vec_t tbl[$];
    t_ctl sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic t_ctl e_fetch(input logic rdy);
        t_ctl c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
        return c;
    endfunction
    function automatic t_ctl e_decode();
        t_ctl c = '0; c.alu_src_b = 2'b11; return c;
    endfunction
    function automatic t_ctl e_memaddr();
        t_ctl c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; return c;
    endfunction
    function automatic t_ctl e_memread();
        t_ctl c = '0; c.mem_read = 1'b1; c.i_or_d = 1'b1; return c;
    endfunction
    function automatic t_ctl e_memwb();
        t_ctl c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; return c;
    endfunction
    function automatic t_ctl e_memwrite();
        t_ctl c = '0; c.mem_write = 1'b1; c.i_or_d = 1'b1; return c;
    endfunction
    function automatic t_ctl e_rtype();
        t_ctl c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b10; return c;
    endfunction
    function automatic t_ctl e_rwb();
        t_ctl c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; return c;
    endfunction
    function automatic t_ctl e_branch();
        t_ctl c = '0;
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
        return c;
    endfunction
    function automatic t_ctl e_jump();
        t_ctl c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10; return c;
    endfunction
    function automatic t_ctl e_iexec(input logic [3:0] f);
        t_ctl c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.inm = 1'b1; c.alu_op_final = f;
        return c;
    endfunction
    function automatic t_ctl e_iwb(input logic [3:0] f);
        t_ctl c = '0; c.reg_write = 1'b1; c.inm = 1'b1; c.alu_op_final = f; return c;
    endfunction
    function automatic t_ctl e_illegal(input logic t);
        t_ctl c = '0; c.trap = t; return c;
    endfunction

    function automatic t_ctl sample();
        t_ctl s;
        s.pc_write      = bus.pc_write;
        s.pc_write_cond = bus.pc_write_cond;
        s.i_or_d        = bus.i_or_d;
        s.mem_read      = bus.mem_read;
        s.mem_write     = bus.mem_write;
        s.ir_write      = bus.ir_write;
        s.mem_to_reg    = bus.mem_to_reg;
        s.reg_dst       = bus.reg_dst;
        s.reg_write     = bus.reg_write;
        s.alu_src_a     = bus.alu_src_a;
        s.alu_src_b     = bus.alu_src_b;
        s.alu_op        = bus.alu_op;
        s.inm           = bus.inm;
        s.alu_op_final  = bus.alu_op_final;
        s.pc_source     = bus.pc_source;
        s.mem_timeout   = bus.mem_timeout;
        s.trap          = bus.trap;
        return s;
    endfunction

    function automatic void add(input string n, input logic [5:0] op, input logic rdy,
                                input logic rst, input t_ctl e);
        vec_t v;
        v.name = n; v.op = op; v.rdy = rdy; v.rst = rst; v.exp = e;
        tbl.push_back(v);
    endfunction

    // Drive one cycle of inputs just after the rising edge, queue the expected
    // controls, and compare them at the falling edge.
    task automatic step(input string n, input logic [5:0] op, input logic rdy,
                        input logic rst, input t_ctl e);
        t_ctl got;
        t_ctl want;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        reset         = rst;
        sb.push_back(e);
        @(negedge clk);
        got  = sample();
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        t_ctl e;
        reset = 1'b1; bus.opcode = 6'd0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        add("reset_state",   6'h00, 1'b0, 1'b1, e_fetch(1'b0));
        add("r_fetch",       6'h00, 1'b1, 1'b0, e_fetch(1'b1));
        add("r_decode",      6'h00, 1'b1, 1'b0, e_decode());
        add("r_rtype",       6'h00, 1'b1, 1'b0, e_rtype());
        add("r_rwb",         6'h00, 1'b1, 1'b0, e_rwb());
        add("lw_fetch",      6'h23, 1'b1, 1'b0, e_fetch(1'b1));
        add("lw_decode",     6'h23, 1'b1, 1'b0, e_decode());
        add("lw_memaddr",    6'h23, 1'b0, 1'b0, e_memaddr());
        add("lw_memread_w1", 6'h23, 1'b0, 1'b0, e_memread());
        add("lw_memread_w2", 6'h23, 1'b0, 1'b0, e_memread());
        add("lw_memread_w3", 6'h23, 1'b0, 1'b0, e_memread());
        add("lw_memread_ok", 6'h23, 1'b1, 1'b0, e_memread());
        add("lw_memwb",      6'h23, 1'b1, 1'b0, e_memwb());
        add("sw_fetch",      6'h2b, 1'b1, 1'b0, e_fetch(1'b1));
        add("sw_decode",     6'h2b, 1'b1, 1'b0, e_decode());
        add("sw_memaddr",    6'h2b, 1'b1, 1'b0, e_memaddr());
        add("sw_memwrite",   6'h2b, 1'b1, 1'b0, e_memwrite());
        add("ori_fetch",     6'h0d, 1'b1, 1'b0, e_fetch(1'b1));
        add("ori_decode",    6'h0d, 1'b1, 1'b0, e_decode());
        add("ori_iexec",     6'h00, 1'b1, 1'b0, e_iexec(4'b0001));
        add("ori_iwb",       6'h00, 1'b1, 1'b0, e_iwb(4'b0001));
        add("slti_fetch",    6'h0a, 1'b1, 1'b0, e_fetch(1'b1));
        add("slti_decode",   6'h0a, 1'b1, 1'b0, e_decode());
        add("slti_iexec",    6'h3f, 1'b1, 1'b0, e_iexec(4'b0111));
        add("slti_iwb",      6'h3f, 1'b1, 1'b0, e_iwb(4'b0111));
        add("addi_fetch",    6'h08, 1'b1, 1'b0, e_fetch(1'b1));
        add("addi_decode",   6'h08, 1'b1, 1'b0, e_decode());
        add("addi_iexec",    6'h08, 1'b1, 1'b0, e_iexec(4'b0010));
        add("addi_iwb",      6'h08, 1'b1, 1'b0, e_iwb(4'b0010));
        add("rst_lw_fetch",  6'h23, 1'b1, 1'b0, e_fetch(1'b1));
        add("rst_lw_decode", 6'h23, 1'b1, 1'b0, e_decode());
        add("rst_lw_maddr",  6'h23, 1'b1, 1'b0, e_memaddr());
        add("rst_lw_mread",  6'h23, 1'b0, 1'b1, e_memread());
        add("rst_lw_after",  6'h04, 1'b0, 1'b0, e_fetch(1'b0));
        add("beq_fetch",     6'h04, 1'b1, 1'b0, e_fetch(1'b1));
        add("beq_decode",    6'h04, 1'b1, 1'b0, e_decode());
        add("beq_branch",    6'h04, 1'b1, 1'b0, e_branch());
        add("j_fetch",       6'h02, 1'b1, 1'b0, e_fetch(1'b1));
        add("j_decode",      6'h02, 1'b1, 1'b0, e_decode());
        add("j_jump",        6'h02, 1'b0, 1'b0, e_jump());

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].name, tbl[i].op, tbl[i].rdy, tbl[i].rst, tbl[i].exp);
        end

        // Long fetch stall: mem_timeout appears after the 15th waiting cycle.
        for (int k = 1; k <= 20; k++) begin
            e = e_fetch(1'b0);
            e.mem_timeout = (k >= 16);
            step("timeout_wait", 6'h00, 1'b0, 1'b0, e);
        end
        e = e_fetch(1'b0);
        e.mem_timeout = 1'b1;
        step("reset_mid_stall", 6'h00, 1'b0, 1'b1, e);
        step("after_reset", 6'h00, 1'b0, 1'b0, e_fetch(1'b0));

        step("ill_fetch",  6'h3f, 1'b1, 1'b0, e_fetch(1'b1));
        step("ill_decode", 6'h3f, 1'b1, 1'b0, e_decode());
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        step("ill_trap1",     6'h00, 1'b1, 1'b0, e_illegal(1'b1));
        step("ill_trap2",     6'h00, 1'b1, 1'b0, e_illegal(1'b1));
        step("ill_trap3",     6'h00, 1'b1, 1'b0, e_illegal(1'b1));
        step("ill_trap_rst",  6'h00, 1'b0, 1'b1, e_illegal(1'b1));
        step("ill_after_rst", 6'h00, 1'b0, 1'b0, e_fetch(1'b0));
`else
        step("ill_nop",    6'h00, 1'b1, 1'b0, e_illegal(1'b0));
        step("ill_fetch2", 6'h00, 1'b1, 1'b0, e_fetch(1'b1));
        step("ill_decode2", 6'h00, 1'b1, 1'b0, e_decode());
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
